// File: rtl/tspattern_gen_if.sv
// tspattern_gen_if: byte-stream handshake between the TS pattern
// source (master) and a tx sink (slave).
interface tspattern_gen_if;
  logic [7:0] odat;
  logic       osop;
  logic       oeop;
  logic       oval;
  logic       irdy;

  modport master (
    output odat, osop, oeop, oval,
    input  irdy
  );

  modport slave (
    input  odat, osop, oeop, oval,
    output irdy
  );
endinterface

// File: rtl/tspattern_gen.sv
// tspattern_gen: MPEG-TS test packet source, 188/204-byte packets with
// header, counter/PRBS/null/fixed payload and a programmable gap.
module tspattern_gen #(
  parameter int          PKT_LEN   = 188,
  parameter logic [14:0] PRBS_SEED = 15'h4A80,
  parameter int          GAP_W     = 8
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ien,
  input  logic [1:0]       imode,
  input  logic [12:0]      ipid,
  input  logic [7:0]       ibyte,
  input  logic [GAP_W-1:0] igap,
  tspattern_gen_if.master  tx,
  output logic [31:0]      opkt_cnt
);
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_e;

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       dat_q, dat_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             val_q, val_d;
  logic [1:0]       mode_q, mode_d;
  logic [12:0]      pid_q, pid_d;
  logic [7:0]       byte_q, byte_d;
  logic [3:0]       cc_q, cc_d;
  logic [14:0]      prbs_q, prbs_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [7:0]  nidx, nb, pbyte;
  logic [14:0] pnext;
  logic        is_null, nb_prbs, start;

  assign tx.odat  = dat_q;
  assign tx.osop  = sop_q;
  assign tx.oeop  = eop_q;
  assign tx.oval  = val_q;
  assign opkt_cnt = cnt_q;

  // eight PRBS15 steps per payload byte, first bit lands in the MSB
  always_comb begin
    pnext = prbs_q;
    pbyte = 8'h00;
    for (int k = 0; k < 8; k++) begin
      pbyte = {pbyte[6:0], pnext[14] ^ pnext[13]};
      pnext = {pnext[13:0], pnext[14] ^ pnext[13]};
    end
  end

  always_comb begin
    nidx    = idx_q + 8'd1;
    is_null = (mode_q == 2'd2);
    nb      = 8'h00;
    nb_prbs = 1'b0;
    unique case (1'b1)
      nidx == 8'd1:   nb = is_null ? 8'h1F : {3'b010, pid_q[12:8]};
      nidx == 8'd2:   nb = is_null ? 8'hFF : pid_q[7:0];
      nidx == 8'd3:   nb = {4'h1, is_null ? 4'h0 : cc_q};
      nidx >= 8'd188: nb = 8'h00;
      default: begin
        unique case (mode_q)
          2'd0: nb = nidx - 8'd4;
          2'd1: begin
            nb      = pbyte;
            nb_prbs = 1'b1;
          end
          2'd2:    nb = 8'hFF;
          default: nb = byte_q;
        endcase
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    val_d   = val_q;
    mode_d  = mode_q;
    pid_d   = pid_q;
    byte_d  = byte_q;
    cc_d    = cc_q;
    prbs_d  = prbs_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: start = ien;
      HDR, PAY: begin
        if (val_q && tx.irdy) begin
          if (eop_q) begin
            cnt_d = cnt_q + 32'd1;
            if (!is_null) cc_d = cc_q + 4'd1;
            val_d = 1'b0;
            sop_d = 1'b0;
            eop_d = 1'b0;
            dat_d = 8'h00;
            if (igap != '0) begin
              state_d = GAP;
              gap_d   = igap;
            end else if (ien) begin
              start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d   = nidx;
            dat_d   = nb;
            sop_d   = 1'b0;
            eop_d   = (nidx == LAST);
            state_d = (nidx >= 8'd4) ? PAY : HDR;
            if (nb_prbs) prbs_d = pnext;
          end
        end
      end
      default: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          if (ien) start = 1'b1;
          else state_d = IDLE;
        end
      end
    endcase
    // config is only sampled at a packet start
    if (start) begin
      state_d = HDR;
      idx_d   = 8'd0;
      dat_d   = 8'h47;
      sop_d   = 1'b1;
      eop_d   = 1'b0;
      val_d   = 1'b1;
      mode_d  = imode;
      pid_d   = ipid;
      byte_d  = ibyte;
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      dat_q   <= 8'h00;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      val_q   <= 1'b0;
      mode_q  <= 2'd0;
      pid_q   <= 13'd0;
      byte_q  <= 8'h00;
      cc_q    <= 4'd0;
      prbs_q  <= PRBS_SEED;
      gap_q   <= '0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      pid_q   <= pid_d;
      byte_q  <= byte_d;
      cc_q    <= cc_d;
      prbs_q  <= prbs_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
